param_alu: RTL and testbench
============================

PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request; accepted only on a clock edge with ready=1.
REQ-005 SHALL have port instruction  input  3  opcode, sampled at accept.
REQ-006 SHALL have ports reg_a, reg_b, r_beq  input  WIDTH each  operands, sampled at accept.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept.
REQ-008 SHALL have port done  output  1  one-cycle pulse when solution is valid.
REQ-009 SHALL have port solution  output  WIDTH  result, held until the next done.
REQ-010 SHALL have port jump_data  output  WIDTH  branch target, updated only by BNZ.
REQ-011 SHALL have port overflow_signal  output  1  overflow flag, updated with each done.

Function
REQ-012 SHALL implement opcodes: 000 ADD, 001 SUB, 010 MUL, 110 BEQ, 111 BNZ; 011/100/101 undefined.
REQ-013 SHALL use FSM states IDLE, EXEC, MUL_ITER, DONE; IDLE->EXEC on accept; EXEC->DONE for non-MUL; EXEC->MUL_ITER for MUL; MUL_ITER->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 SHALL assert ready only in IDLE; start while ready=0 SHALL be ignored, not queued.
REQ-015 SHALL pulse done in DONE: 2 cycles after accept for non-MUL, WIDTH+2 cycles after accept for MUL.
REQ-016 ADD: solution = (a+b) mod 2^WIDTH; overflow = carry out of bit WIDTH-1.
REQ-017 SUB: solution = (a-b) mod 2^WIDTH; overflow = 1 iff a<b (unsigned borrow).
REQ-018 MUL: shift-add, one partial product per cycle; solution = low WIDTH bits; overflow = 1 iff high WIDTH bits nonzero.
REQ-019 BEQ: solution = 1 if a==b else 0; overflow = 0.
REQ-020 BNZ: solution = a; jump_data = a if r_beq==0, b if r_beq==1, unchanged otherwise; overflow = 0.
REQ-021 Undefined opcodes: solution = 0, overflow = 0, non-MUL latency.
REQ-022 Operand changes after accept SHALL NOT affect the in-flight result.
REQ-023 start asserted in the DONE cycle SHALL be ignored; the next accept is possible in the following IDLE cycle.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, solution=0, jump_data=0, overflow_signal=0, done=0; ready=1 after release.
REQ-025 Reset during MUL_ITER SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro PARAM_ALU_MUL_EN defined: MUL per REQ-018; undefined: opcode 010 SHALL behave as undefined (REQ-021) and no multiplier logic SHALL be instantiated.

Structure
REQ-027 Opcode constants and FSM state encoding SHALL live in shared package param_alu_pkg.
REQ-028 The iterative multiplier SHALL be a sub-module seq_multiplier (WIDTH parameter, start/done handshake, 2*WIDTH product), instantiated only under PARAM_ALU_MUL_EN.

Verification
REQ-029 WIDTH=8, ADD a=200 b=100 -> done 2 cycles after accept, solution=44, overflow_signal=1.
REQ-030 WIDTH=8, SUB a=5 b=7 -> solution=254, overflow_signal=1; SUB a=7 b=5 -> solution=2, overflow_signal=0.
REQ-031 WIDTH=8, MUL a=16 b=17 -> done at cycle 10 after accept, solution=16, overflow_signal=1; MUL a=12 b=10 -> solution=120, overflow_signal=0; start held high throughout MUL -> no second accept before DONE.
REQ-032 BNZ a=0x10 b=0x20 r_beq=1 -> jump_data=0x20, solution=0x10; then BNZ r_beq=3 -> jump_data stays 0x20.
REQ-033 reset_n low 4 cycles into MUL -> no done, all outputs 0, ready=1 after release; new ADD 3+4 -> solution=7.
REQ-034 Build without PARAM_ALU_MUL_EN, opcode 010 a=3 b=3 -> solution=0, overflow_signal=0, done 2 cycles after accept.

Source files
------------

// File: rtl/param_alu_pkg.sv
// Shared opcode and FSM state encodings for param_alu and its multiplier.
package param_alu_pkg;

    typedef logic [2:0] opcode_t;
    typedef logic [1:0] state_t;

    localparam opcode_t OP_ADD = 3'b000;
    localparam opcode_t OP_SUB = 3'b001;
    localparam opcode_t OP_MUL = 3'b010;
    localparam opcode_t OP_BEQ = 3'b110;
    localparam opcode_t OP_BNZ = 3'b111;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_EXEC     = 2'd1;
    localparam state_t ST_MUL_ITER = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

endpackage

// File: rtl/param_alu_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH
// iterations after start, done_o pulses once the 2*WIDTH product is final.
module seq_multiplier
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        done_d   = 1'b0;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            count_d  = CNT_W'(WIDTH);
        end else if (count_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            done_d   = (count_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/param_alu.sv
// Multi-cycle ALU with ready/start/done handshake. Define PARAM_ALU_MUL_EN to
// build the iterative multiplier; otherwise opcode 010 acts as undefined.
module param_alu
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       instruction,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] r_beq,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] solution,
    output logic [WIDTH-1:0] jump_data,
    output logic             overflow_signal
);

    state_t           state_q, state_d;
    opcode_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] beq_q, beq_d;
    logic [WIDTH-1:0] sol_q, sol_d;
    logic [WIDTH-1:0] jmp_q, jmp_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf;
    logic             is_mul;

`ifdef PARAM_ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Multiplier loads at accept so its WIDTH iterations overlap EXEC.
    assign mul_start = (state_q == ST_IDLE) && start && (instruction == OP_MUL);

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_i   (mul_start),
        .a_i       (reg_a),
        .b_i       (reg_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign is_mul = (op_q == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle result for every opcode that is not a multiply.
    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        diff_w   = {1'b0, a_q} - {1'b0, b_q};
        exec_res = '0;
        exec_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_res = sum_w[WIDTH-1:0];
                exec_ovf = sum_w[WIDTH];
            end
            OP_SUB: begin
                exec_res = diff_w[WIDTH-1:0];
                exec_ovf = (a_q < b_q);
            end
            OP_BEQ:  exec_res = WIDTH'(a_q == b_q);
            OP_BNZ:  exec_res = a_q;
            default: exec_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        beq_d   = beq_q;
        sol_d   = sol_q;
        ovf_d   = ovf_q;
        jmp_d   = jmp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXEC;
                    op_d    = instruction;
                    a_d     = reg_a;
                    b_d     = reg_b;
                    beq_d   = r_beq;
                end
            end
            ST_EXEC: begin
                if (is_mul) begin
                    state_d = ST_MUL_ITER;
                end else begin
                    state_d = ST_DONE;
                    sol_d   = exec_res;
                    ovf_d   = exec_ovf;
                    // Any r_beq other than 0 or 1 leaves the branch target alone.
                    if (op_q == OP_BNZ) begin
                        if (beq_q == '0) begin
                            jmp_d = a_q;
                        end else if (beq_q == WIDTH'(1)) begin
                            jmp_d = b_q;
                        end
                    end
                end
            end
            ST_MUL_ITER: begin
`ifdef PARAM_ALU_MUL_EN
                if (mul_done) begin
                    state_d = ST_DONE;
                    sol_d   = mul_product[WIDTH-1:0];
                    ovf_d   = |mul_product[2*WIDTH-1:WIDTH];
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            beq_q   <= '0;
            sol_q   <= '0;
            ovf_q   <= 1'b0;
            jmp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            beq_q   <= beq_d;
            sol_q   <= sol_d;
            ovf_q   <= ovf_d;
            jmp_q   <= jmp_d;
        end
    end

    assign ready           = (state_q == ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign solution        = sol_q;
    assign jump_data       = jmp_q;
    assign overflow_signal = ovf_q;

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu (WIDTH=8); expectations follow PARAM_ALU_MUL_EN.
module tb_param_alu;

    localparam int WIDTH = 8;
    localparam int NVEC  = 17;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [2:0]       instruction;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] r_beq;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] solution;
    logic [WIDTH-1:0] jump_data;
    logic             overflow_signal;

    param_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .instruction     (instruction),
        .reg_a           (reg_a),
        .reg_b           (reg_b),
        .r_beq           (r_beq),
        .ready           (ready),
        .done            (done),
        .solution        (solution),
        .jump_data       (jump_data),
        .overflow_signal (overflow_signal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] beq;
        logic [WIDTH-1:0] sol;
        logic             ovf;
        logic [WIDTH-1:0] jmp;
        int               lat;
        bit               hold;
    } vec_t;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] sol;
        logic             ovf;
        logic [WIDTH-1:0] jmp;
        int               lat;
        time              t_acc;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

`ifdef PARAM_ALU_MUL_EN
    localparam int  MUL_LAT   = WIDTH + 2;
    localparam int  RST_DELAY = 4;
    localparam bit  MUL_ON    = 1'b1;
`else
    localparam int  MUL_LAT   = 2;
    localparam int  RST_DELAY = 1;
    localparam bit  MUL_ON    = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] beq, input logic [7:0] sol, input logic ovf,
                                input logic [7:0] jmp, input int lat, input bit hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.beq = beq; v.sol = sol;
        v.ovf = ovf; v.jmp = jmp; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(3'b000, 8'd200, 8'd100, 8'd0, 8'd44,  1'b1, 8'h00, 2, 1'b0);
        vecs[1]  = mk(3'b001, 8'd5,   8'd7,   8'd0, 8'd254, 1'b1, 8'h00, 2, 1'b0);
        vecs[2]  = mk(3'b001, 8'd7,   8'd5,   8'd0, 8'd2,   1'b0, 8'h00, 2, 1'b0);
        vecs[3]  = mk(3'b000, 8'd255, 8'd1,   8'd0, 8'd0,   1'b1, 8'h00, 2, 1'b0);
        // 16*17=0x110, 12*10=120, 255*255=0xFE01, 3*3=9
        vecs[4]  = mk(3'b010, 8'd16,  8'd17,  8'd0, MUL_ON ? 8'd16  : 8'd0, MUL_ON, 8'h00, MUL_LAT, 1'b1);
        vecs[5]  = mk(3'b010, 8'd12,  8'd10,  8'd0, MUL_ON ? 8'd120 : 8'd0, 1'b0,   8'h00, MUL_LAT, 1'b0);
        vecs[6]  = mk(3'b010, 8'd255, 8'd255, 8'd0, MUL_ON ? 8'd1   : 8'd0, MUL_ON, 8'h00, MUL_LAT, 1'b0);
        vecs[7]  = mk(3'b010, 8'd3,   8'd3,   8'd0, MUL_ON ? 8'd9   : 8'd0, 1'b0,   8'h00, MUL_LAT, 1'b0);
        vecs[8]  = mk(3'b110, 8'd9,   8'd9,   8'd0, 8'd1,   1'b0, 8'h00, 2, 1'b0);
        vecs[9]  = mk(3'b110, 8'd9,   8'd8,   8'd0, 8'd0,   1'b0, 8'h00, 2, 1'b0);
        vecs[10] = mk(3'b111, 8'h10,  8'h20,  8'd1, 8'h10,  1'b0, 8'h20, 2, 1'b0);
        vecs[11] = mk(3'b111, 8'h30,  8'h40,  8'd3, 8'h30,  1'b0, 8'h20, 2, 1'b0);
        vecs[12] = mk(3'b111, 8'h55,  8'h66,  8'd0, 8'h55,  1'b0, 8'h55, 2, 1'b0);
        vecs[13] = mk(3'b011, 8'd3,   8'd3,   8'd0, 8'd0,   1'b0, 8'h55, 2, 1'b0);
        vecs[14] = mk(3'b101, 8'd200, 8'd100, 8'd0, 8'd0,   1'b0, 8'h55, 2, 1'b0);
        vecs[15] = mk(3'b110, 8'd0,   8'd0,   8'd0, 8'd1,   1'b0, 8'h55, 2, 1'b1);
        // Issued after the mid-operation reset, so jump_data is back to 0.
        vecs[16] = mk(3'b000, 8'd3,   8'd4,   8'd0, 8'd7,   1'b0, 8'h00, 2, 1'b0);
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = int'((($time + 5) - e.t_acc) / 10);
                check($sformatf("v%0d_solution", e.idx), solution, e.sol);
                check($sformatf("v%0d_overflow", e.idx), overflow_signal, e.ovf);
                check($sformatf("v%0d_jump_data", e.idx), jump_data, e.jmp);
                check($sformatf("v%0d_latency", e.idx), lat, e.lat);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clock);
        while (!ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!ready) check(name, ready, 1);
    endtask

    task automatic issue(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        wait_ready($sformatf("v%0d_ready_timeout", idx));
        start       = 1'b1;
        instruction = v.op;
        reg_a       = v.a;
        reg_b       = v.b;
        r_beq       = v.beq;
        @(posedge clock);
        e.idx = idx; e.sol = v.sol; e.ovf = v.ovf; e.jmp = v.jmp; e.lat = v.lat; e.t_acc = $time;
        sb.push_back(e);
        #1;
        if (!v.hold) begin
            // Scramble inputs right after accept; the in-flight result must not move.
            start       = 1'b0;
            instruction = ~v.op;
            reg_a       = ~v.a;
            reg_b       = ~v.b;
            r_beq       = ~v.beq;
        end else begin
            int n       = 0;
            int ready_hi = 0;
            do begin
                @(negedge clock);
                if (ready) ready_hi++;
                n++;
            end while (!done && n < 60);
            if (!done) check($sformatf("v%0d_hold_done_timeout", idx), done, 1);
            check($sformatf("v%0d_hold_ready_low", idx), ready_hi, 0);
            @(negedge clock);
            start = 1'b0;
            check($sformatf("v%0d_hold_ready_after_done", idx), ready, 1);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        instruction = 3'b000;
        reg_a       = '0;
        reg_b       = '0;
        r_beq       = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_solution", solution, 0);
        check("rst_jump_data", jump_data, 0);
        check("rst_overflow", overflow_signal, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) issue(i);

        // Reset mid-operation: the pending result is discarded and never signalled.
        wait_ready("abort_ready_timeout");
        while (sb.size() != 0) @(negedge clock);
        start       = 1'b1;
        instruction = 3'b010;
        reg_a       = 8'd5;
        reg_b       = 8'd5;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (RST_DELAY) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_solution", solution, 0);
        check("abort_jump_data", jump_data, 0);
        check("abort_overflow", overflow_signal, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clock);
        check("abort_ready_after_release", ready, 1);

        issue(16);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("drain_scoreboard", sb.size(), 0);
        end
        repeat (4) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
